// File: rtl/mem_model_lat.sv
// Byte-masked word RAM behind a valid/ready request/response handshake.
// Supports programmable wait states, out-of-range error reporting and access/stall counters.
module mem_model_lat #(
    parameter int    DATA_W    = 64,
    parameter int    DEPTH     = 512,
    parameter int    ADDR_W    = 29,
    parameter int    LATENCY   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_wr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [31:0]         acc_cnt,
    output logic [31:0]         stall_cnt
);
    localparam int MASK_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state;
    logic [7:0]          wait_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   addr_p0;
    logic                wr_p0;
    logic [DATA_W-1:0]   wdata_p0;
    logic [MASK_W-1:0]   wmask_p0;

    logic                accept;
    logic                enter_resp;
    logic                mem_we;
    logic [ADDR_W-1:0]   op_addr;
    logic                op_wr;
    logic [DATA_W-1:0]   op_wdata;
    logic [MASK_W-1:0]   op_wmask;
    logic [IDX_W-1:0]    op_idx;
    logic                op_in_range;
    logic [DATA_W-1:0]   cur_word;
    logic [DATA_W-1:0]   rsp_word;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wdata,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    assign accept     = req_valid & req_ready;
    assign enter_resp = (state == S_IDLE) ? (accept && (LATENCY == 0))
                                          : ((state == S_WAIT) && (wait_cnt == 8'd0));

    // With no wait states the RAM access happens on the accept edge, so it uses the live request.
    always_comb begin
        if (state == S_IDLE) begin
            op_addr  = req_addr;
            op_wr    = req_wr;
            op_wdata = req_wdata;
            op_wmask = req_wmask;
        end else begin
            op_addr  = addr_p0;
            op_wr    = wr_p0;
            op_wdata = wdata_p0;
            op_wmask = wmask_p0;
        end
    end

    assign op_idx      = op_addr[IDX_W-1:0];
    assign op_in_range = {1'b0, op_addr} < DEPTH_X;
    assign cur_word    = mem[op_idx];

    always_comb begin
        rsp_word = '0;
        if (op_in_range) begin
            rsp_word = op_wr ? merge_bytes(cur_word, op_wdata, op_wmask) : cur_word;
        end
    end

    assign mem_we = enter_resp & op_wr & op_in_range;

    // stage p0: request captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= req_addr;
            wr_p0    <= req_wr;
            wdata_p0 <= req_wdata;
            wmask_p0 <= req_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[op_idx] <= rsp_word;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            acc_cnt   <= '0;
            stall_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (req_valid && !req_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        acc_cnt   <= acc_cnt + 32'd1;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 8'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
            // stage p1: response registered on the edge that enters RESP
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rsp_word;
                rsp_err   <= ~op_in_range;
            end
        end
    end

endmodule
